tlb: RTL and testbench

- Fully associative joint TLB; it is the responder for the CP0 TLB write and read ports.
- It holds TLBNUM entries and serves two registered translation search ports: port 0 for pre-IF/IF, port 1 for EX/MEM and TLBP.
- For TLBP it produces the probe result in the {miss, index} form CP0 latches into Index.

---
 rtl/tlb_pkg.sv | 31 +++
 rtl/tlb_if.sv | 87 ++++++++
 rtl/tlb_search.sv | 84 ++++++++
 rtl/tlb.sv | 118 +++++++++++
 tb/tb_tlb.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tlb_pkg.sv
// Shared field widths and page-half layout for the joint TLB.
// A page half is always carried as the concatenation {pfn, c, d, v}.
package tlb_pkg;

  localparam int VPN2_W = 19;
  localparam int ASID_W = 8;
  localparam int PFN_W  = 20;
  localparam int C_W    = 3;

  typedef struct packed {
    logic [PFN_W-1:0] pfn;
    logic [C_W-1:0]   c;
    logic             d;
    logic             v;
  } page_t;

  localparam int PAGE_W = $bits(page_t);

  function automatic page_t make_page(input logic [PFN_W-1:0] pfn,
                                      input logic [C_W-1:0] c,
                                      input logic d,
                                      input logic v);
    page_t p;
    p.pfn = pfn;
    p.c   = c;
    p.d   = d;
    p.v   = v;
    return p;
  endfunction

endpackage

// File: rtl/tlb_if.sv
// Bundle of the TLB search, write and read ports; slave is the TLB side.
// Search handshake: s_req is a one-cycle strobe sampled at a rising edge; s_rvalid rises for exactly
// the following cycle with the result, which is then held until the next accepted request.
interface tlb_if #(
  parameter int TLBNUM = 16
) ();
  import tlb_pkg::*;
  localparam int TLBNUM_WIDTH = $clog2(TLBNUM);

  logic                    s0_req;
  logic [VPN2_W-1:0]       s0_vpn2;
  logic                    s0_odd_page;
  logic [ASID_W-1:0]       s0_asid;
  logic                    s0_found;
  logic [TLBNUM_WIDTH-1:0] s0_index;
  logic [PFN_W-1:0]        s0_pfn;
  logic [C_W-1:0]          s0_c;
  logic                    s0_d;
  logic                    s0_v;
  logic                    s0_rvalid;

  logic                    s1_req;
  logic [VPN2_W-1:0]       s1_vpn2;
  logic                    s1_odd_page;
  logic [ASID_W-1:0]       s1_asid;
  logic                    s1_found;
  logic [TLBNUM_WIDTH-1:0] s1_index;
  logic [PFN_W-1:0]        s1_pfn;
  logic [C_W-1:0]          s1_c;
  logic                    s1_d;
  logic                    s1_v;
  logic                    s1_rvalid;

  logic [TLBNUM_WIDTH:0]   tlbp_result;

  logic                    we;
  logic [TLBNUM_WIDTH-1:0] w_index;
  logic [VPN2_W-1:0]       w_vpn2;
  logic [ASID_W-1:0]       w_asid;
  logic                    w_g;
  logic [PFN_W-1:0]        w_pfn0;
  logic [C_W-1:0]          w_c0;
  logic                    w_d0;
  logic                    w_v0;
  logic [PFN_W-1:0]        w_pfn1;
  logic [C_W-1:0]          w_c1;
  logic                    w_d1;
  logic                    w_v1;

  logic [TLBNUM_WIDTH-1:0] r_index;
  logic [VPN2_W-1:0]       r_vpn2;
  logic [ASID_W-1:0]       r_asid;
  logic                    r_g;
  logic [PFN_W-1:0]        r_pfn0;
  logic [C_W-1:0]          r_c0;
  logic                    r_d0;
  logic                    r_v0;
  logic [PFN_W-1:0]        r_pfn1;
  logic [C_W-1:0]          r_c1;
  logic                    r_d1;
  logic                    r_v1;

  modport slave (
    input  s0_req, s0_vpn2, s0_odd_page, s0_asid,
    output s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v, s0_rvalid,
    input  s1_req, s1_vpn2, s1_odd_page, s1_asid,
    output s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v, s1_rvalid,
    output tlbp_result,
    input  we, w_index, w_vpn2, w_asid, w_g,
    input  w_pfn0, w_c0, w_d0, w_v0, w_pfn1, w_c1, w_d1, w_v1,
    input  r_index,
    output r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1
  );

  modport master (
    output s0_req, s0_vpn2, s0_odd_page, s0_asid,
    input  s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v, s0_rvalid,
    output s1_req, s1_vpn2, s1_odd_page, s1_asid,
    input  s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v, s1_rvalid,
    input  tlbp_result,
    output we, w_index, w_vpn2, w_asid, w_g,
    output w_pfn0, w_c0, w_d0, w_v0, w_pfn1, w_c1, w_d1, w_v1,
    output r_index,
    input  r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1
  );

endinterface

// File: rtl/tlb_search.sv
// One registered translation search port: associative match, lowest-index priority encode,
// even/odd half select and the result registers.
module tlb_search
  import tlb_pkg::*;
#(
  parameter int TLBNUM       = 16,
  parameter int TLBNUM_WIDTH = $clog2(TLBNUM)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req,
  input  logic [VPN2_W-1:0]         vpn2,
  input  logic                      odd_page,
  input  logic [ASID_W-1:0]         asid,
  input  logic [TLBNUM-1:0]         e,
  input  logic [TLBNUM-1:0]         g,
  input  logic [TLBNUM*VPN2_W-1:0]  vpn2_flat,
  input  logic [TLBNUM*ASID_W-1:0]  asid_flat,
  input  logic [TLBNUM*PAGE_W-1:0]  page0_flat,
  input  logic [TLBNUM*PAGE_W-1:0]  page1_flat,
  output logic                      found,
  output logic [TLBNUM_WIDTH-1:0]   index,
  output logic [PFN_W-1:0]          pfn,
  output logic [C_W-1:0]            c,
  output logic                      d,
  output logic                      v,
  output logic                      rvalid
);

  logic [TLBNUM-1:0]       match;
  logic [TLBNUM_WIDTH-1:0] hit_idx;
  logic                    hit;
  page_t                   sel_page;
  page_t                   page_q;

  // The v bit plays no part in matching; an invalid page still reports a hit.
  always_comb begin
    match = '0;
    for (int i = 0; i < TLBNUM; i++) begin
      match[i] = e[i] && (vpn2_flat[i*VPN2_W +: VPN2_W] == vpn2) &&
                 (g[i] || (asid_flat[i*ASID_W +: ASID_W] == asid));
    end
  end

  // Scanning downward leaves the lowest matching index as the winner.
  always_comb begin
    hit_idx = '0;
    for (int i = TLBNUM - 1; i >= 0; i--) begin
      if (match[i]) hit_idx = TLBNUM_WIDTH'(i);
    end
  end

  assign hit = |match;

  always_comb begin
    sel_page = '0;
    if (hit) begin
      sel_page = odd_page ? page_t'(page1_flat[int'(hit_idx)*PAGE_W +: PAGE_W])
                          : page_t'(page0_flat[int'(hit_idx)*PAGE_W +: PAGE_W]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      found  <= 1'b0;
      index  <= '0;
      page_q <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= req;
      if (req) begin
        found  <= hit;
        index  <= hit_idx;
        page_q <= sel_page;
      end
    end
  end

  assign pfn = page_q.pfn;
  assign c   = page_q.c;
  assign d   = page_q.d;
  assign v   = page_q.v;

endmodule

// File: rtl/tlb.sv
// Fully associative joint TLB: entry storage, CP0 write/read ports, two search ports and the
// TLBP probe result.
module tlb
  import tlb_pkg::*;
#(
  parameter int TLBNUM = 16,
  localparam int TLBNUM_WIDTH = $clog2(TLBNUM)
) (
  input logic clk,
  input logic reset,
  tlb_if.slave bus
);

  logic [TLBNUM-1:0]  e_q;
  logic [TLBNUM-1:0]  g_q;
  logic [VPN2_W-1:0]  vpn2_q  [TLBNUM];
  logic [ASID_W-1:0]  asid_q  [TLBNUM];
  page_t              page0_q [TLBNUM];
  page_t              page1_q [TLBNUM];

  logic [TLBNUM*VPN2_W-1:0] vpn2_flat;
  logic [TLBNUM*ASID_W-1:0] asid_flat;
  logic [TLBNUM*PAGE_W-1:0] page0_flat;
  logic [TLBNUM*PAGE_W-1:0] page1_flat;

  // Only the present bits are reset; an entry's fields are meaningless until it is written.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_q <= '0;
    end else if (bus.we) begin
      e_q[bus.w_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (bus.we) begin
      vpn2_q[bus.w_index]  <= bus.w_vpn2;
      asid_q[bus.w_index]  <= bus.w_asid;
      g_q[bus.w_index]     <= bus.w_g;
      page0_q[bus.w_index] <= make_page(bus.w_pfn0, bus.w_c0, bus.w_d0, bus.w_v0);
      page1_q[bus.w_index] <= make_page(bus.w_pfn1, bus.w_c1, bus.w_d1, bus.w_v1);
    end
  end

  always_comb begin
    vpn2_flat  = '0;
    asid_flat  = '0;
    page0_flat = '0;
    page1_flat = '0;
    for (int i = 0; i < TLBNUM; i++) begin
      vpn2_flat[i*VPN2_W +: VPN2_W]  = vpn2_q[i];
      asid_flat[i*ASID_W +: ASID_W]  = asid_q[i];
      page0_flat[i*PAGE_W +: PAGE_W] = page0_q[i];
      page1_flat[i*PAGE_W +: PAGE_W] = page1_q[i];
    end
  end

  assign bus.r_vpn2 = vpn2_q[bus.r_index];
  assign bus.r_asid = asid_q[bus.r_index];
  assign bus.r_g    = g_q[bus.r_index];
  assign bus.r_pfn0 = page0_q[bus.r_index].pfn;
  assign bus.r_c0   = page0_q[bus.r_index].c;
  assign bus.r_d0   = page0_q[bus.r_index].d;
  assign bus.r_v0   = page0_q[bus.r_index].v;
  assign bus.r_pfn1 = page1_q[bus.r_index].pfn;
  assign bus.r_c1   = page1_q[bus.r_index].c;
  assign bus.r_d1   = page1_q[bus.r_index].d;
  assign bus.r_v1   = page1_q[bus.r_index].v;

  tlb_search #(.TLBNUM(TLBNUM), .TLBNUM_WIDTH(TLBNUM_WIDTH)) u_search0 (
    .clk        (clk),
    .reset      (reset),
    .req        (bus.s0_req),
    .vpn2       (bus.s0_vpn2),
    .odd_page   (bus.s0_odd_page),
    .asid       (bus.s0_asid),
    .e          (e_q),
    .g          (g_q),
    .vpn2_flat  (vpn2_flat),
    .asid_flat  (asid_flat),
    .page0_flat (page0_flat),
    .page1_flat (page1_flat),
    .found      (bus.s0_found),
    .index      (bus.s0_index),
    .pfn        (bus.s0_pfn),
    .c          (bus.s0_c),
    .d          (bus.s0_d),
    .v          (bus.s0_v),
    .rvalid     (bus.s0_rvalid)
  );

  tlb_search #(.TLBNUM(TLBNUM), .TLBNUM_WIDTH(TLBNUM_WIDTH)) u_search1 (
    .clk        (clk),
    .reset      (reset),
    .req        (bus.s1_req),
    .vpn2       (bus.s1_vpn2),
    .odd_page   (bus.s1_odd_page),
    .asid       (bus.s1_asid),
    .e          (e_q),
    .g          (g_q),
    .vpn2_flat  (vpn2_flat),
    .asid_flat  (asid_flat),
    .page0_flat (page0_flat),
    .page1_flat (page1_flat),
    .found      (bus.s1_found),
    .index      (bus.s1_index),
    .pfn        (bus.s1_pfn),
    .c          (bus.s1_c),
    .d          (bus.s1_d),
    .v          (bus.s1_v),
    .rvalid     (bus.s1_rvalid)
  );

  // The s1 result registers only load on s1_req and reset to found=0/index=0, so this concat is
  // itself a registered value that resets to {1, 0} and updates exactly with each s1 search.
  assign bus.tlbp_result = {~bus.s1_found, bus.s1_index};

endmodule

// File: tb/tb_tlb.sv
// Bench for the joint TLB: directed scenarios plus random traffic, checked by a scoreboard
// against a first-match linear-search model of the entry table.
module tb_tlb;
  import tlb_pkg::*;

  localparam int TLBNUM = 16;
  localparam int IW     = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  tlb_if #(.TLBNUM(TLBNUM)) bus ();

  tlb #(.TLBNUM(TLBNUM)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int compared   = 0;
  int mismatched = 0;

  // reference table
  logic        m_e       [TLBNUM];
  logic [18:0] m_vpn2    [TLBNUM];
  logic [7:0]  m_asid    [TLBNUM];
  logic        m_g       [TLBNUM];
  page_t       m_p0      [TLBNUM];
  page_t       m_p1      [TLBNUM];
  logic        m_written [TLBNUM];

  // result record: {found, index, pfn, c, d, v}
  logic [29:0] exp0_q[$];
  logic [29:0] exp1_q[$];

  logic [18:0] vpn_pool[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [29:0] lookup(input logic [18:0] vpn2, input logic odd,
                                         input logic [7:0] asid);
    for (int i = 0; i < TLBNUM; i++) begin
      if (m_e[i] && m_vpn2[i] == vpn2 && (m_g[i] || m_asid[i] == asid))
        return {1'b1, IW'(i), (odd ? m_p1[i] : m_p0[i])};
    end
    return '0;
  endfunction

  // Model update: searches see the table as it was before this edge's write.
  always @(posedge clk) begin
    if (reset) begin
      exp0_q.delete();
      exp1_q.delete();
      for (int i = 0; i < TLBNUM; i++) m_e[i] = 1'b0;
    end else begin
      if (bus.s0_req) exp0_q.push_back(lookup(bus.s0_vpn2, bus.s0_odd_page, bus.s0_asid));
      if (bus.s1_req) exp1_q.push_back(lookup(bus.s1_vpn2, bus.s1_odd_page, bus.s1_asid));
      if (bus.we) begin
        m_e[bus.w_index]       = 1'b1;
        m_written[bus.w_index] = 1'b1;
        m_vpn2[bus.w_index]    = bus.w_vpn2;
        m_asid[bus.w_index]    = bus.w_asid;
        m_g[bus.w_index]       = bus.w_g;
        m_p0[bus.w_index]      = make_page(bus.w_pfn0, bus.w_c0, bus.w_d0, bus.w_v0);
        m_p1[bus.w_index]      = make_page(bus.w_pfn1, bus.w_c1, bus.w_d1, bus.w_v1);
      end
    end
  end

  task automatic cmp_res(input string name, input logic [29:0] act, input logic [29:0] exp);
    // on a miss only found/index are defined
    logic [29:0] mask;
    mask = exp[29] ? '1 : {5'b11111, 25'b0};
    chk(name, 64'(act & mask), 64'(exp & mask));
  endtask

  // Monitor: pops one expectation per presented result.
  always @(posedge clk) begin
    logic [29:0] e0, e1;
    #1;
    if (bus.s0_rvalid) begin
      if (exp0_q.size() == 0) chk("s0_unexpected_rvalid", 1, 0);
      else begin
        e0 = exp0_q.pop_front();
        cmp_res("s0_result", {bus.s0_found, bus.s0_index, bus.s0_pfn, bus.s0_c, bus.s0_d, bus.s0_v}, e0);
      end
    end else if (exp0_q.size() != 0) begin
      chk("s0_missing_rvalid", 0, 1);
      exp0_q.delete();
    end
    if (bus.s1_rvalid) begin
      if (exp1_q.size() == 0) chk("s1_unexpected_rvalid", 1, 0);
      else begin
        e1 = exp1_q.pop_front();
        cmp_res("s1_result", {bus.s1_found, bus.s1_index, bus.s1_pfn, bus.s1_c, bus.s1_d, bus.s1_v}, e1);
        chk("tlbp_result", 64'(bus.tlbp_result), 64'({~e1[29], e1[28:25]}));
      end
    end else if (exp1_q.size() != 0) begin
      chk("s1_missing_rvalid", 0, 1);
      exp1_q.delete();
    end
  end

  task automatic set_s0(input logic [18:0] vpn2, input logic odd, input logic [7:0] asid);
    bus.s0_req = 1'b1; bus.s0_vpn2 = vpn2; bus.s0_odd_page = odd; bus.s0_asid = asid;
  endtask

  task automatic set_s1(input logic [18:0] vpn2, input logic odd, input logic [7:0] asid);
    bus.s1_req = 1'b1; bus.s1_vpn2 = vpn2; bus.s1_odd_page = odd; bus.s1_asid = asid;
  endtask

  task automatic set_w(input logic [IW-1:0] idx, input logic [18:0] vpn2, input logic [7:0] asid,
                       input logic g, input page_t p0, input page_t p1);
    bus.we = 1'b1; bus.w_index = idx; bus.w_vpn2 = vpn2; bus.w_asid = asid; bus.w_g = g;
    bus.w_pfn0 = p0.pfn; bus.w_c0 = p0.c; bus.w_d0 = p0.d; bus.w_v0 = p0.v;
    bus.w_pfn1 = p1.pfn; bus.w_c1 = p1.c; bus.w_d1 = p1.d; bus.w_v1 = p1.v;
  endtask

  // Drivers start at a negedge; tick crosses one rising edge and returns at the next negedge.
  task automatic tick();
    @(posedge clk);
    #2;
    bus.s0_req = 1'b0;
    bus.s1_req = 1'b0;
    bus.we     = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_read(input string name);
    if (m_written[bus.r_index]) begin
      chk({name, "_hdr"}, 64'({bus.r_vpn2, bus.r_asid, bus.r_g}),
          64'({m_vpn2[bus.r_index], m_asid[bus.r_index], m_g[bus.r_index]}));
      chk({name, "_pages"},
          64'({bus.r_pfn0, bus.r_c0, bus.r_d0, bus.r_v0, bus.r_pfn1, bus.r_c1, bus.r_d1, bus.r_v1}),
          64'({m_p0[bus.r_index], m_p1[bus.r_index]}));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [18:0] vpn_keep;
    int          hit_list[5];
    int          k;

    for (int i = 0; i < TLBNUM; i++) begin
      m_e[i] = 1'b0; m_written[i] = 1'b0;
    end
    for (int i = 0; i < 8; i++) vpn_pool[i] = 19'($urandom_range(0, 19'h7FFFF));
    hit_list = '{2, 3, 4, 7, 9};

    bus.s0_req = 0; bus.s0_vpn2 = 0; bus.s0_odd_page = 0; bus.s0_asid = 0;
    bus.s1_req = 0; bus.s1_vpn2 = 0; bus.s1_odd_page = 0; bus.s1_asid = 0;
    bus.we = 0; bus.w_index = 0; bus.w_vpn2 = 0; bus.w_asid = 0; bus.w_g = 0;
    bus.w_pfn0 = 0; bus.w_c0 = 0; bus.w_d0 = 0; bus.w_v0 = 0;
    bus.w_pfn1 = 0; bus.w_c1 = 0; bus.w_d1 = 0; bus.w_v1 = 0;
    bus.r_index = 0;

    // clock/reset
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset_s0_rvalid", 64'(bus.s0_rvalid), 0);
    chk("reset_s0_found", 64'(bus.s0_found), 0);
    chk("reset_s1_rvalid", 64'(bus.s1_rvalid), 0);
    chk("reset_s1_index", 64'(bus.s1_index), 0);
    chk("reset_tlbp", 64'(bus.tlbp_result), 64'h10);

    // empty table miss
    set_s0(19'h00001, 1'b0, 8'h00);
    tick();
    chk("empty_s0_rvalid", 64'(bus.s0_rvalid), 1);
    chk("empty_s0_found", 64'(bus.s0_found), 0);
    chk("empty_tlbp", 64'(bus.tlbp_result), 64'h10);

    // asid-qualified entry, odd half
    set_w(4'd3, 19'h12345, 8'h05, 1'b0, make_page(20'hAAAAA, 3'd0, 1'b0, 1'b1),
          make_page(20'hBBBBB, 3'd3, 1'b1, 1'b1));
    tick();
    set_s1(19'h12345, 1'b1, 8'h05);
    tick();
    chk("idx3_found", 64'(bus.s1_found), 1);
    chk("idx3_index", 64'(bus.s1_index), 3);
    chk("idx3_pfn", 64'(bus.s1_pfn), 64'hBBBBB);
    chk("idx3_cdv", 64'({bus.s1_c, bus.s1_d, bus.s1_v}), 64'b011_1_1);
    chk("idx3_tlbp", 64'(bus.tlbp_result), 64'h03);
    set_s1(19'h12345, 1'b1, 8'h06);
    tick();
    chk("idx3_other_asid_found", 64'(bus.s1_found), 0);
    chk("idx3_other_asid_tlbp", 64'(bus.tlbp_result), 64'h10);

    // global entry with invalid even page, plus same-cycle read
    set_w(4'd7, 19'h0ABCD, 8'h11, 1'b1, make_page(20'h12121, 3'd2, 1'b0, 1'b0),
          make_page(20'h34343, 3'd1, 1'b1, 1'b1));
    tick();
    set_s0(19'h0ABCD, 1'b0, 8'hEE);
    bus.r_index = 4'd7;
    #1;
    chk("read7_g", 64'(bus.r_g), 1);
    chk("read7_pfn0", 64'(bus.r_pfn0), 64'h12121);
    tick();
    chk("global_found", 64'(bus.s0_found), 1);
    chk("global_index", 64'(bus.s0_index), 7);
    chk("global_v", 64'(bus.s0_v), 0);

    // duplicate hit: lowest index wins
    set_w(4'd9, 19'h33333, 8'h22, 1'b0, make_page(20'h99999, 3'd1, 1'b0, 1'b1),
          make_page(20'h99998, 3'd1, 1'b0, 1'b1));
    tick();
    set_w(4'd2, 19'h33333, 8'h22, 1'b0, make_page(20'h22222, 3'd2, 1'b1, 1'b1),
          make_page(20'h22223, 3'd2, 1'b1, 1'b1));
    tick();
    set_s1(19'h33333, 1'b0, 8'h22);
    tick();
    chk("dup_index", 64'(bus.s1_index), 2);
    chk("dup_pfn", 64'(bus.s1_pfn), 64'h22222);

    // write/search at the same edge, then the following edge
    set_w(4'd4, 19'h44444, 8'h01, 1'b0, make_page(20'h44440, 3'd0, 1'b0, 1'b1),
          make_page(20'h44441, 3'd0, 1'b0, 1'b1));
    set_s0(19'h44444, 1'b0, 8'h01);
    tick();
    chk("collide_found", 64'(bus.s0_found), 0);
    set_s0(19'h44444, 1'b0, 8'h01);
    tick();
    chk("after_write_found", 64'(bus.s0_found), 1);
    chk("after_write_index", 64'(bus.s0_index), 4);

    // write/read collision on entry 3
    bus.r_index = 4'd3;
    set_w(4'd3, 19'h55555, 8'h05, 1'b1, make_page(20'h55550, 3'd5, 1'b1, 1'b0),
          make_page(20'h55551, 3'd6, 1'b0, 1'b1));
    #1;
    chk("rw_collide_old", 64'(bus.r_vpn2), 64'h12345);
    tick();
    chk("rw_collide_new", 64'(bus.r_vpn2), 64'h55555);
    check_read("read3");

    // both ports every cycle on mixed hits and misses
    for (int n = 0; n < 20; n++) begin
      k = hit_list[$urandom_range(0, 4)];
      set_s0(m_vpn2[k], 1'($urandom_range(0, 1)), m_asid[k]);
      k = hit_list[$urandom_range(0, 4)];
      if ($urandom_range(0, 3) == 0) set_s1(19'($urandom), 1'($urandom_range(0, 1)), m_asid[k]);
      else set_s1(m_vpn2[k], 1'($urandom_range(0, 1)), m_asid[k]);
      tick();
    end

    // random writes, searches and reads from small pools
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0)
        set_w(IW'($urandom_range(0, TLBNUM - 1)), vpn_pool[$urandom_range(0, 7)],
              8'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0),
              make_page(20'($urandom), 3'($urandom), 1'($urandom), 1'($urandom)),
              make_page(20'($urandom), 3'($urandom), 1'($urandom), 1'($urandom)));
      if ($urandom_range(0, 3) != 0)
        set_s0(vpn_pool[$urandom_range(0, 7)], 1'($urandom_range(0, 1)), 8'($urandom_range(0, 3)));
      if ($urandom_range(0, 3) != 0)
        set_s1(vpn_pool[$urandom_range(0, 7)], 1'($urandom_range(0, 1)), 8'($urandom_range(0, 3)));
      bus.r_index = IW'($urandom_range(0, TLBNUM - 1));
      #1;
      check_read("rand_read");
      tick();
    end

    // reset while a search is in flight; the table empties
    vpn_keep = 19'h44444;
    for (int i = 0; i < TLBNUM; i++) if (m_e[i]) vpn_keep = m_vpn2[i];
    set_s1(vpn_keep, 1'b0, 8'h00);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midreset_s1_rvalid", 64'(bus.s1_rvalid), 0);
    chk("midreset_s1_found", 64'(bus.s1_found), 0);
    chk("midreset_tlbp", 64'(bus.tlbp_result), 64'h10);
    for (int n = 0; n < 8; n++) begin
      set_s0(vpn_pool[n], 1'b0, 8'h00);
      set_s1(vpn_pool[n], 1'b1, 8'h01);
      tick();
      chk("post_reset_s0_miss", 64'(bus.s0_found), 0);
      chk("post_reset_s1_miss", 64'(bus.s1_found), 0);
    end

    repeat (3) @(negedge clk);
    chk("s0_queue_drained", 64'(exp0_q.size()), 0);
    chk("s1_queue_drained", 64'(exp1_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
